// File: rtl/cpu_sequencer.sv
// cpu_sequencer: per-class instruction micro-state sequencer with stall, restart,
// sticky halt and illegal-opcode/timeout detection. Define CPU_SEQ_IRQ_EN for interrupt entry.
module cpu_sequencer #(
    parameter int OPCODE_W  = 8,
    parameter int STATE_W   = 4,
    parameter int CYCLE_W   = 4,
    parameter int MAX_CYCLE = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                stall,
    input  logic                restart,
`ifdef CPU_SEQ_IRQ_EN
    input  logic                irq,
    output logic                irq_ack,
`endif
    output logic [STATE_W-1:0]  state,
    output logic [CYCLE_W-1:0]  cycle,
    output logic                instr_done,
    output logic                halted,
    output logic                decode_err
);

    typedef enum logic [STATE_W-1:0] {
        STATE_NEXT       = STATE_W'(0),
        STATE_FETCH_PC   = STATE_W'(1),
        STATE_FETCH_INST = STATE_W'(2),
        STATE_HALT       = STATE_W'(3),
        STATE_OUT_A      = STATE_W'(4),
        STATE_MOV_FETCH  = STATE_W'(5),
        STATE_MOV_LOAD   = STATE_W'(6),
        STATE_MOV_STORE  = STATE_W'(7),
        STATE_JUMP       = STATE_W'(8),
        STATE_LDI        = STATE_W'(9),
        STATE_LOAD_ADDR  = STATE_W'(10),
        STATE_RAM_B      = STATE_W'(11),
        STATE_ALU_OP     = STATE_W'(12),
        STATE_IRQ_PUSH   = STATE_W'(13),
        STATE_IRQ_VEC    = STATE_W'(14)
    } state_t;

    typedef enum logic [2:0] {
        C_ILL, C_HLT, C_OUT, C_MOV, C_JMP, C_LDI, C_ALU, C_MEM
    } op_class_t;

    // HLT sits inside the MOV pattern space, so it must be matched first
    localparam logic [OPCODE_W-1:0] PATTERN_HLT = 8'b0111_0110;
    localparam logic [OPCODE_W-1:0] PATTERN_MOV = 8'b01??_????;
    localparam logic [OPCODE_W-1:0] PATTERN_LDI = 8'b00??_?110;
    localparam logic [OPCODE_W-1:0] PATTERN_ALU = 8'b10??_????;
    localparam logic [OPCODE_W-1:0] OP_OUT      = 8'hD3;
    localparam logic [OPCODE_W-1:0] OP_JMP      = 8'hC3;
    localparam logic [OPCODE_W-1:0] OP_JEZ      = 8'hCA;
    localparam logic [OPCODE_W-1:0] OP_JNZ      = 8'hC2;
    localparam logic [OPCODE_W-1:0] OP_LDA      = 8'h3A;
    localparam logic [OPCODE_W-1:0] OP_STA      = 8'h32;

    state_t                r_state, w_state_nxt, w_adv_state;
    logic [CYCLE_W-1:0]    r_cycle, w_cycle_nxt;
    logic [OPCODE_W-1:0]   r_op, w_op_nxt, w_op;
    logic                  r_err, w_err_nxt, w_adv_err;
    op_class_t             w_class;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= STATE_NEXT;
            r_cycle <= '0;
            r_op    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cycle <= w_cycle_nxt;
            r_op    <= w_op_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Live opcode at the decode edge, latched copy for every later step
    always_comb begin
        w_op    = (r_cycle == CYCLE_W'(2)) ? opcode : r_op;
        w_class = C_ILL;
        casez (w_op)
            PATTERN_HLT:              w_class = C_HLT;
            PATTERN_MOV:              w_class = C_MOV;
            OP_OUT:                   w_class = C_OUT;
            OP_JMP, OP_JEZ, OP_JNZ:   w_class = C_JMP;
            PATTERN_LDI:              w_class = C_LDI;
            PATTERN_ALU:              w_class = C_ALU;
            OP_LDA, OP_STA:           w_class = C_MEM;
            default:                  w_class = C_ILL;
        endcase
    end

    always_comb begin
        w_adv_state = STATE_NEXT;
        w_adv_err   = 1'b0;
        if (r_cycle == CYCLE_W'(MAX_CYCLE)) begin
            w_adv_err = 1'b1;
        end else begin
            case (r_cycle)
                CYCLE_W'(0): w_adv_state = STATE_FETCH_PC;
                CYCLE_W'(1): w_adv_state = STATE_FETCH_INST;
                CYCLE_W'(2): begin
                    case (w_class)
                        C_HLT:   w_adv_state = STATE_HALT;
                        C_OUT:   w_adv_state = STATE_OUT_A;
                        C_MOV:   w_adv_state = STATE_MOV_FETCH;
                        C_ILL:   w_adv_err   = 1'b1;
                        default: w_adv_state = STATE_FETCH_PC;
                    endcase
                end
                CYCLE_W'(3): begin
                    case (w_class)
                        C_MOV:        w_adv_state = STATE_MOV_LOAD;
                        C_JMP:        w_adv_state = STATE_JUMP;
                        C_LDI:        w_adv_state = STATE_LDI;
                        C_ALU, C_MEM: w_adv_state = STATE_LOAD_ADDR;
                        default:      w_adv_state = STATE_NEXT;
                    endcase
                end
                CYCLE_W'(4): begin
                    case (w_class)
                        C_MOV:   w_adv_state = STATE_MOV_STORE;
                        C_ALU:   w_adv_state = STATE_RAM_B;
                        default: w_adv_state = STATE_NEXT;
                    endcase
                end
                CYCLE_W'(5): w_adv_state = (w_class == C_ALU) ? STATE_ALU_OP : STATE_NEXT;
                default:     w_adv_state = STATE_NEXT;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cycle_nxt = r_cycle;
        w_op_nxt    = r_op;
        w_err_nxt   = 1'b0;
        if (restart) begin
            w_state_nxt = STATE_NEXT;
            w_cycle_nxt = '0;
        end else if (!stall) begin
`ifdef CPU_SEQ_IRQ_EN
            if (r_state == STATE_IRQ_PUSH) begin
                w_state_nxt = STATE_IRQ_VEC;
            end else if (r_state == STATE_IRQ_VEC) begin
                w_state_nxt = STATE_FETCH_PC;
                w_cycle_nxt = CYCLE_W'(1);
            end else if (irq && (r_cycle == '0 || r_state == STATE_HALT)) begin
                w_state_nxt = STATE_IRQ_PUSH;
                w_cycle_nxt = '0;
            end else
`endif
            if (r_state != STATE_HALT) begin
                w_state_nxt = w_adv_state;
                w_cycle_nxt = (w_adv_state == STATE_NEXT) ? '0 : r_cycle + CYCLE_W'(1);
                w_err_nxt   = w_adv_err;
                if (r_cycle == CYCLE_W'(2))
                    w_op_nxt = opcode;
            end
        end
    end

    assign state      = r_state;
    assign cycle      = r_cycle;
    assign instr_done = (r_state == STATE_NEXT);
    assign halted     = (r_state == STATE_HALT);
    assign decode_err = r_err;
`ifdef CPU_SEQ_IRQ_EN
    assign irq_ack    = (r_state == STATE_IRQ_PUSH);
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: queue-based instruction model compared every
// cycle, plus hand-computed literal expectations on directed vectors.
module tb_cpu_sequencer;

    localparam logic [3:0] S_NEXT = 4'd0,  S_FP  = 4'd1,  S_FI  = 4'd2,  S_HALT = 4'd3,
                           S_OUT  = 4'd4,  S_MF  = 4'd5,  S_ML  = 4'd6,  S_MS   = 4'd7,
                           S_JUMP = 4'd8,  S_LDI = 4'd9,  S_LA  = 4'd10, S_RB   = 4'd11,
                           S_ALU  = 4'd12, S_IP  = 4'd13, S_IV  = 4'd14;

    logic       clk = 1'b0;
    logic       reset = 1'b1, stall = 1'b0, restart = 1'b0;
    logic [7:0] opcode = 8'h00;
    logic [3:0] state, cycle;
    logic       instr_done, halted, decode_err;
`ifdef CPU_SEQ_IRQ_EN
    logic       irq = 1'b0, irq_ack;
`endif

    int n_chk = 0, n_pass = 0;

    logic [3:0] m_state = S_NEXT;
    int         m_cyc = 0;
    bit         m_err = 1'b0;
    logic [3:0] m_rest[$];
    bit         chk_en = 1'b0;

    cpu_sequencer dut (
        .clk(clk), .reset(reset), .opcode(opcode), .stall(stall), .restart(restart),
`ifdef CPU_SEQ_IRQ_EN
        .irq(irq), .irq_ack(irq_ack),
`endif
        .state(state), .cycle(cycle), .instr_done(instr_done), .halted(halted),
        .decode_err(decode_err)
    );

    always #5 clk = ~clk;

    // Remaining states of an instruction after FETCH_PC, FETCH_INST; empty means illegal
    task automatic load_seq(input logic [7:0] op);
        m_rest.delete();
        if (op == 8'h76)                            m_rest = '{S_HALT};
        else if (op[7:6] == 2'b01)                  m_rest = '{S_MF, S_ML, S_MS, S_NEXT};
        else if (op == 8'hD3)                       m_rest = '{S_OUT, S_NEXT};
        else if (op == 8'hC3 || op == 8'hCA || op == 8'hC2)
                                                    m_rest = '{S_FP, S_JUMP, S_NEXT};
        else if (op[7:6] == 2'b00 && op[2:0] == 3'b110)
                                                    m_rest = '{S_FP, S_LDI, S_NEXT};
        else if (op[7:6] == 2'b10)                  m_rest = '{S_FP, S_LA, S_RB, S_ALU, S_NEXT};
        else if (op == 8'h3A || op == 8'h32)        m_rest = '{S_FP, S_LA, S_NEXT};
    endtask

    task automatic model_step();
        logic [3:0] nx;
        m_err = 1'b0;
        if (reset || restart) begin
            m_state = S_NEXT; m_cyc = 0; m_rest.delete();
        end else if (stall) begin
        end
`ifdef CPU_SEQ_IRQ_EN
        else if (m_state == S_IP) m_state = S_IV;
        else if (m_state == S_IV) begin m_state = S_FP; m_cyc = 1; end
        else if (irq && (m_state == S_NEXT || m_state == S_HALT)) begin
            m_state = S_IP; m_cyc = 0; m_rest.delete();
        end
`endif
        else if (m_state != S_HALT) begin
            if (m_cyc == 0)      nx = S_FP;
            else if (m_cyc == 1) nx = S_FI;
            else begin
                if (m_cyc == 2) load_seq(opcode);
                if (m_rest.size() == 0) begin
                    nx = S_NEXT;
                    m_err = (m_cyc == 2);
                end else nx = m_rest.pop_front();
            end
            m_state = nx;
            m_cyc   = (nx == S_NEXT) ? 0 : m_cyc + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        bit ok;
        if (chk_en) begin
            ok = (state === m_state) && (cycle === 4'(m_cyc)) &&
                 (instr_done === (m_state == S_NEXT)) && (halted === (m_state == S_HALT)) &&
                 (decode_err === m_err);
`ifdef CPU_SEQ_IRQ_EN
            ok = ok && (irq_ack === (m_state == S_IP));
`endif
            n_chk++;
            if (ok) n_pass++;
            else $display("FAIL model t=%0t: state=%0d cycle=%0d done=%b halt=%b err=%b, expected state=%0d cycle=%0d err=%b",
                          $time, state, cycle, instr_done, halted, decode_err, m_state, m_cyc, m_err);
        end
    end

    task automatic chk_lit(input string nm, input logic [3:0] es, input int ec);
        n_chk++;
        if (state === es && cycle === 4'(ec)) n_pass++;
        else $display("FAIL %s: state=%0d cycle=%0d, expected state=%0d cycle=%0d", nm, state, cycle, es, ec);
    endtask

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b, expected %b", nm, act, exp);
    endtask

    task automatic run_instr(input logic [7:0] op, input bit stall_pat);
        int n = 0;
        opcode = op;
        tick();
        while (!instr_done && n < 16) begin
            stall = stall_pat && (n % 3 == 1);
            tick();
            n++;
        end
        stall = 1'b0;
        if (!instr_done) begin
            tick();
            chk_bit("run_timeout", instr_done, 1'b1);
        end
    endtask

    initial begin
        logic [7:0] ops[10];
        ops = '{8'hC3, 8'hCA, 8'hC2, 8'h3A, 8'h32, 8'hA7, 8'h06, 8'h80, 8'h41, 8'hD3};

        reset = 1'b1; tick(); tick();
        chk_en = 1'b1;
        chk_lit("reset", S_NEXT, 0);
        chk_bit("reset_done", instr_done, 1'b1);
        chk_bit("reset_halted", halted, 1'b0);
        chk_bit("reset_err", decode_err, 1'b0);
        reset = 1'b0;

        // OUT: NEXT, FETCH_PC, FETCH_INST, OUT_A, NEXT
        opcode = 8'hD3;
        tick(); chk_lit("out_1", S_FP, 1);  chk_bit("out_done_1", instr_done, 1'b0);
        tick(); chk_lit("out_2", S_FI, 2);
        tick(); chk_lit("out_3", S_OUT, 3);
        tick(); chk_lit("out_4", S_NEXT, 0); chk_bit("out_done_4", instr_done, 1'b1);

        // ALU with 2-clock stall in RAM_B: 9 clocks NEXT to NEXT
        opcode = 8'h80;
        repeat (5) tick();
        chk_lit("alu_rb", S_RB, 5);
        stall = 1'b1;
        tick(); chk_lit("alu_stall_1", S_RB, 5);
        tick(); chk_lit("alu_stall_2", S_RB, 5);
        stall = 1'b0;
        tick(); chk_lit("alu_op", S_ALU, 6);
        tick(); chk_lit("alu_next", S_NEXT, 0);

        // HLT: sticky, ignores stall, left by restart
        opcode = 8'h76;
        repeat (3) tick();
        chk_lit("hlt_reach", S_HALT, 3);
        for (int i = 0; i < 20; i++) begin
            stall = (i % 4 == 2);
            tick();
        end
        stall = 1'b0;
        chk_lit("hlt_hold", S_HALT, 3);
        chk_bit("hlt_halted", halted, 1'b1);
        restart = 1'b1; tick(); chk_lit("hlt_restart", S_NEXT, 0);
        restart = 1'b0; tick(); chk_lit("hlt_resume", S_FP, 1);

        // Illegal opcode: one-clock decode_err, next instruction decodes normally
        opcode = 8'hFF;
        tick(); chk_lit("ill_fi", S_FI, 2);
        tick(); chk_lit("ill_next", S_NEXT, 0); chk_bit("ill_err", decode_err, 1'b1);
        opcode = 8'h3E;
        tick(); chk_bit("ill_err_clr", decode_err, 1'b0);
        tick(); tick(); tick(); chk_lit("ldi_ldi", S_LDI, 4);
        tick(); chk_lit("ldi_next", S_NEXT, 0);

        // MOV with opcode changed after decode: latched class wins
        opcode = 8'h41;
        tick(); tick(); tick(); chk_lit("mov_mf", S_MF, 3);
        opcode = 8'hD3;
        tick(); chk_lit("mov_ml", S_ML, 4);
        tick(); chk_lit("mov_ms", S_MS, 5);
        tick(); chk_lit("mov_next", S_NEXT, 0);

        // Remaining opcode classes, plain and with periodic stalls
        for (int i = 0; i < 10; i++) run_instr(ops[i], 1'b0);
        for (int i = 0; i < 10; i++) run_instr(ops[i], 1'b1);

        // reset beats stall mid-ALU; restart beats stall mid-MOV
        opcode = 8'h80;
        repeat (4) tick();
        chk_lit("rst_mid_la", S_LA, 4);
        reset = 1'b1; stall = 1'b1; tick(); chk_lit("rst_stall", S_NEXT, 0);
        reset = 1'b0; tick(); chk_lit("stall_at_next", S_NEXT, 0);
        stall = 1'b0;
        opcode = 8'h41;
        repeat (4) tick();
        restart = 1'b1; stall = 1'b1; tick(); chk_lit("restart_stall", S_NEXT, 0);
        restart = 1'b0; stall = 1'b0;

`ifdef CPU_SEQ_IRQ_EN
        irq = 1'b1; opcode = 8'hD3;
        tick(); chk_lit("irq_push", S_IP, 0); chk_bit("irq_ack", irq_ack, 1'b1);
        irq = 1'b0;
        stall = 1'b1; tick(); chk_lit("irq_stall", S_IP, 0); stall = 1'b0;
        tick(); chk_lit("irq_vec", S_IV, 0); chk_bit("irq_ack_clr", irq_ack, 1'b0);
        tick(); chk_lit("irq_resume", S_FP, 1);
        run_instr(8'hD3, 1'b0);
        opcode = 8'h76; repeat (3) tick();
        irq = 1'b1; tick(); chk_lit("irq_from_halt", S_IP, 0);
        irq = 1'b0; tick(); tick(); chk_lit("irq_halt_resume", S_FP, 1);
        opcode = 8'hD3; tick(); tick(); tick();
`endif

        tick();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
